zacore_memory: RTL and testbench

Memory stage of the Zacore pipeline: consumer of `execute_memory_if_t` and the source of the execute stage's stall input. Non-memory instructions pass to writeback through one output register. Loads and stores are issued as single outstanding transactions on a req/ack data-memory port, with byte-lane steering, load sign/zero extension and misalignment faulting. Honours the pipeline-wide invalidate.

---
 rtl/zacore_pkg.sv | 46 ++++
 rtl/zacore_memory_lane.sv | 39 +++
 rtl/zacore_memory.sv | 145 ++++++++++++++
 tb/tb_zacore_memory.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zacore_pkg.sv
// Shared types for the Zacore pipeline: stage-to-stage interfaces and memory op encodings.
package zacore_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_idx;
    logic            rd_wen;
    logic [XLEN-1:0] alu_result;
    mem_op_e         mem_op;
    mem_size_e       mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] store_data;
  } execute_memory_if_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_idx;
    logic            rd_wen;
    logic [XLEN-1:0] rd_data;
    logic            fault;
  } memory_writeback_if_t;

  // A half must sit on an even byte, a word on a 4-byte boundary.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] lane);
    case (size)
      SIZE_HALF: is_misaligned = lane[0];
      SIZE_WORD: is_misaligned = (lane != 2'b00);
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/zacore_memory_lane.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
module zacore_memory_lane
  import zacore_pkg::*;
(
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] storeData_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] loadData_o
);

  logic [15:0] laneBits;

  always_comb begin
    wdata_o    = storeData_i;
    wstrb_o    = 4'b1111;
    loadData_o = rdata_i;
    laneBits   = 16'(rdata_i >> {lane_i, 3'b000});
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o    = 4'b0001 << lane_i;
        wdata_o    = {4{storeData_i[7:0]}};
        loadData_o = unsigned_i ? {24'b0, laneBits[7:0]}
                                : {{24{laneBits[7]}}, laneBits[7:0]};
      end
      SIZE_HALF: begin
        wstrb_o    = 4'b0011 << lane_i;
        wdata_o    = {2{storeData_i[15:0]}};
        loadData_o = unsigned_i ? {16'b0, laneBits}
                                : {{16{laneBits[15]}}, laneBits};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/zacore_memory.sv
// Zacore memory stage: passes ALU results to writeback and runs one outstanding
// req/ack data-memory transaction at a time, stalling execute while it is busy.
module zacore_memory
  import zacore_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  execute_memory_if_t   i_execute_memory_if,
  output logic                 o_stall,
  input  logic                 i_invalidate,
  output memory_writeback_if_t o_memory_writeback_if,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [XLEN-1:0]      o_dmem_addr,
  output logic [XLEN-1:0]      o_dmem_wdata,
  output logic [3:0]           o_dmem_wstrb,
  input  logic                 i_dmem_ack,
  input  logic [XLEN-1:0]      i_dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e               state_q, state_d;
  memory_writeback_if_t wb_q, wb_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [XLEN-1:0]      storeData_q, storeData_d;
  mem_size_e            size_q, size_d;
  logic                 we_q, we_d;
  logic                 unsigned_q, unsigned_d;
  logic [4:0]           rdIdx_q, rdIdx_d;
  logic                 rdWen_q, rdWen_d;

  logic [XLEN-1:0]      laneWdata;
  logic [3:0]           laneWstrb;
  logic [XLEN-1:0]      loadData;

  // Steering works off the latched request so the bus stays stable until ack.
  zacore_memory_lane u_lane (
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .lane_i      (addr_q[1:0]),
    .storeData_i (storeData_q),
    .rdata_i     (i_dmem_rdata),
    .wdata_o     (laneWdata),
    .wstrb_o     (laneWstrb),
    .loadData_o  (loadData)
  );

  always_comb begin
    state_d     = state_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    size_d      = size_q;
    we_d        = we_q;
    unsigned_d  = unsigned_q;
    rdIdx_d     = rdIdx_q;
    rdWen_d     = rdWen_q;
    case (state_q)
      IDLE: begin
        if (i_execute_memory_if.valid && !i_invalidate) begin
          case (i_execute_memory_if.mem_op)
            MEM_LOAD, MEM_STORE: begin
              if (is_misaligned(i_execute_memory_if.mem_size, i_execute_memory_if.alu_result[1:0])) begin
                wb_d.valid   = 1'b1;
                wb_d.rd_idx  = i_execute_memory_if.rd_idx;
                wb_d.rd_wen  = 1'b0;
                wb_d.rd_data = i_execute_memory_if.alu_result;
                wb_d.fault   = 1'b1;
              end else begin
                addr_d      = i_execute_memory_if.alu_result;
                storeData_d = i_execute_memory_if.store_data;
                size_d      = i_execute_memory_if.mem_size;
                we_d        = (i_execute_memory_if.mem_op == MEM_STORE);
                unsigned_d  = i_execute_memory_if.mem_unsigned;
                rdIdx_d     = i_execute_memory_if.rd_idx;
                rdWen_d     = i_execute_memory_if.rd_wen;
                state_d     = REQ;
              end
            end
            default: begin
              wb_d.valid   = 1'b1;
              wb_d.rd_idx  = i_execute_memory_if.rd_idx;
              wb_d.rd_wen  = i_execute_memory_if.rd_wen;
              wb_d.rd_data = i_execute_memory_if.alu_result;
              wb_d.fault   = 1'b0;
            end
          endcase
        end
      end
      REQ: begin
        if (i_dmem_ack) begin
          state_d = IDLE;
          if (!i_invalidate) begin
            wb_d.valid   = 1'b1;
            wb_d.rd_idx  = rdIdx_q;
            wb_d.fault   = 1'b0;
            wb_d.rd_wen  = we_q ? 1'b0 : rdWen_q;
            wb_d.rd_data = we_q ? '0 : loadData;
          end
        end else if (i_invalidate) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_dmem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wb_q        <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      size_q      <= SIZE_BYTE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      rdIdx_q     <= '0;
      rdWen_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      size_q      <= size_d;
      we_q        <= we_d;
      unsigned_q  <= unsigned_d;
      rdIdx_q     <= rdIdx_d;
      rdWen_q     <= rdWen_d;
    end
  end

  assign o_stall               = (state_q != IDLE);
  assign o_dmem_req            = (state_q != IDLE);
  assign o_dmem_we             = we_q;
  assign o_dmem_addr           = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_wdata          = laneWdata;
  assign o_dmem_wstrb          = we_q ? laneWstrb : 4'b0000;
  assign o_memory_writeback_if = wb_q;

endmodule

// File: tb/tb_zacore_memory.sv
// Scoreboard bench for zacore_memory: expected writebacks are queued as stimulus is
// driven and popped by a monitor whenever the stage presents a valid result.
module tb_zacore_memory;
  import zacore_pkg::*;

  typedef struct packed {
    logic [4:0]  rdIdx;
    logic        rdWen;
    logic [31:0] rdData;
    logic        fault;
  } expWb_t;

  logic                 clock;
  logic                 reset;
  execute_memory_if_t   exIf;
  logic                 stall;
  logic                 invalidate;
  memory_writeback_if_t wbIf;
  logic                 dmemReq;
  logic                 dmemWe;
  logic [31:0]          dmemAddr;
  logic [31:0]          dmemWdata;
  logic [3:0]           dmemWstrb;
  logic                 dmemAck;
  logic [31:0]          dmemRdata;

  expWb_t expQ[$];
  expWb_t monExp;
  int     nCompared;
  int     nMismatched;

  zacore_memory dut (
    .i_clk                 (clock),
    .i_rst                 (reset),
    .i_execute_memory_if   (exIf),
    .o_stall               (stall),
    .i_invalidate          (invalidate),
    .o_memory_writeback_if (wbIf),
    .o_dmem_req            (dmemReq),
    .o_dmem_we             (dmemWe),
    .o_dmem_addr           (dmemAddr),
    .o_dmem_wdata          (dmemWdata),
    .o_dmem_wstrb          (dmemWstrb),
    .i_dmem_ack            (dmemAck),
    .i_dmem_rdata          (dmemRdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every writeback valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && wbIf.valid === 1'b1) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_wb: got valid=1 rd_data=%h fault=%b, required no writeback", wbIf.rd_data, wbIf.fault);
      end else begin
        monExp = expQ.pop_front();
        if (wbIf.fault !== monExp.fault || wbIf.rd_wen !== monExp.rdWen ||
            (monExp.rdWen && (wbIf.rd_idx !== monExp.rdIdx || wbIf.rd_data !== monExp.rdData))) begin
          nMismatched++;
          $display("[TB] FAIL wb_content: got idx=%0d wen=%b data=%h fault=%b, required idx=%0d wen=%b data=%h fault=%b",
                   wbIf.rd_idx, wbIf.rd_wen, wbIf.rd_data, wbIf.fault,
                   monExp.rdIdx, monExp.rdWen, monExp.rdData, monExp.fault);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input mem_op_e op, input mem_size_e size, input logic uns,
                               input logic [31:0] alu, input logic [31:0] sd,
                               input logic [4:0] rd, input logic wen);
    exIf.valid        = 1'b1;
    exIf.mem_op       = op;
    exIf.mem_size     = size;
    exIf.mem_unsigned = uns;
    exIf.alu_result   = alu;
    exIf.store_data   = sd;
    exIf.rd_idx       = rd;
    exIf.rd_wen       = wen;
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic wen, input logic [31:0] data, input logic flt);
    expWb_t e;
    e.rdIdx  = rd;
    e.rdWen  = wen;
    e.rdData = data;
    e.fault  = flt;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (stall !== 1'b0 || dmemReq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got stall=%b req=%b, required 0/0", stall, dmemReq);
    end
    nCompared++;
    if (wbIf !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_wb: got %h, required all zero", wbIf);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_nonmem_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        applyStimulus(MEM_NONE, SIZE_WORD, 1'b0, vals[i], 32'h0, 5'd5, 1'b1);
        pushExp(5'd5, 1'b1, vals[i], 1'b0);
      end else begin
        exIf.valid = 1'b0;
      end
      @(negedge clock);
      nCompared++;
      if (stall !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL nonmem_stall: got %b, required 0", stall);
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL nonmem_drain: got %0d pending, required 0", expQ.size());
    end
    @(posedge clock); #1;
  endtask

  localparam logic [31:0] LD_ADDR  [5] = '{32'h1003, 32'h1003, 32'h4002, 32'h5000, 32'h4001};
  localparam mem_size_e   LD_SIZE  [5] = '{SIZE_BYTE, SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BYTE};
  localparam logic        LD_UNS   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [31:0] LD_RDATA [5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'hDEAD_BEEF, 32'h0000_7F00};
  localparam int          LD_WAIT  [5] = '{3, 3, 1, 2, 1};
  localparam logic [31:0] LD_EXP   [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_007F};

  task automatic test_load();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(MEM_LOAD, LD_SIZE[i], LD_UNS[i], LD_ADDR[i], 32'h0, 5'd7, 1'b1);
      pushExp(5'd7, 1'b1, LD_EXP[i], 1'b0);
      @(posedge clock); #1;
      exIf.valid = 1'b0;
      for (int c = 0; c < LD_WAIT[i]; c++) begin
        if (c == LD_WAIT[i] - 1) begin
          dmemAck   = 1'b1;
          dmemRdata = LD_RDATA[i];
        end
        @(negedge clock);
        nCompared++;
        if (dmemReq !== 1'b1 || stall !== 1'b1 || dmemWe !== 1'b0 || dmemWstrb !== 4'b0000) begin
          nMismatched++;
          $display("[TB] FAIL load_req_ctrl: got req=%b stall=%b we=%b wstrb=%b, required 1/1/0/0000",
                   dmemReq, stall, dmemWe, dmemWstrb);
        end
        nCompared++;
        if (dmemAddr !== {LD_ADDR[i][31:2], 2'b00}) begin
          nMismatched++;
          $display("[TB] FAIL load_addr: got %h, required %h", dmemAddr, {LD_ADDR[i][31:2], 2'b00});
        end
        @(posedge clock); #1;
      end
      dmemAck   = 1'b0;
      dmemRdata = 32'h0;
      @(negedge clock);
      nCompared++;
      if (stall !== 1'b0 || dmemReq !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL load_done: got stall=%b req=%b, required 0/0", stall, dmemReq);
      end
      @(posedge clock); #1;
    end
  endtask

  localparam logic [31:0] ST_ADDR  [4] = '{32'h2002, 32'h2101, 32'h2200, 32'h2103};
  localparam mem_size_e   ST_SIZE  [4] = '{SIZE_HALF, SIZE_BYTE, SIZE_WORD, SIZE_BYTE};
  localparam logic [31:0] ST_DATA  [4] = '{32'h1234_ABCD, 32'h0000_00A5, 32'hCAFE_F00D, 32'h1234_5677};
  localparam logic [3:0]  ST_STRB  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
  localparam logic [31:0] ST_WDATA [4] = '{32'hABCD_ABCD, 32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h7777_7777};
  localparam int          ST_WAIT  [4] = '{1, 2, 1, 1};

  task automatic test_store();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(MEM_STORE, ST_SIZE[i], 1'b0, ST_ADDR[i], ST_DATA[i], 5'd3, 1'b1);
      pushExp(5'd3, 1'b0, 32'h0, 1'b0);
      @(posedge clock); #1;
      exIf.valid = 1'b0;
      for (int c = 0; c < ST_WAIT[i]; c++) begin
        if (c == ST_WAIT[i] - 1) dmemAck = 1'b1;
        @(negedge clock);
        nCompared++;
        if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemAddr !== {ST_ADDR[i][31:2], 2'b00}) begin
          nMismatched++;
          $display("[TB] FAIL store_req: got req=%b we=%b addr=%h, required 1/1/%h",
                   dmemReq, dmemWe, dmemAddr, {ST_ADDR[i][31:2], 2'b00});
        end
        nCompared++;
        if (dmemWstrb !== ST_STRB[i] || dmemWdata !== ST_WDATA[i]) begin
          nMismatched++;
          $display("[TB] FAIL store_lanes: got wstrb=%b wdata=%h, required %b %h",
                   dmemWstrb, dmemWdata, ST_STRB[i], ST_WDATA[i]);
        end
        @(posedge clock); #1;
      end
      dmemAck = 1'b0;
    end
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_misaligned();
    applyStimulus(MEM_LOAD, SIZE_WORD, 1'b0, 32'h3001, 32'h0, 5'd9, 1'b1);
    pushExp(5'd9, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      nCompared++;
      if (dmemReq !== 1'b0 || stall !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL misaligned_bus: got req=%b stall=%b, required 0/0", dmemReq, stall);
      end
      @(posedge clock); #1;
      case (i)
        0: begin
          applyStimulus(MEM_STORE, SIZE_HALF, 1'b0, 32'h3003, 32'h5555, 5'd9, 1'b1);
          pushExp(5'd9, 1'b0, 32'h0, 1'b1);
        end
        1: begin
          applyStimulus(MEM_LOAD, SIZE_HALF, 1'b1, 32'h3001, 32'h0, 5'd9, 1'b1);
          pushExp(5'd9, 1'b0, 32'h0, 1'b1);
        end
        2: begin
          applyStimulus(MEM_NONE, SIZE_WORD, 1'b0, 32'h44, 32'h0, 5'd4, 1'b1);
          pushExp(5'd4, 1'b1, 32'h44, 1'b0);
        end
        default: exIf.valid = 1'b0;
      endcase
    end
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_invalidate();
    // Invalidate in the second REQ cycle, ack two cycles later.
    applyStimulus(MEM_LOAD, SIZE_WORD, 1'b0, 32'h6000, 32'h0, 5'd8, 1'b1);
    @(posedge clock); #1;
    exIf.valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      invalidate = (c == 1);
      dmemAck    = (c == 3);
      dmemRdata  = 32'h1111_2222;
      @(negedge clock);
      nCompared++;
      if (dmemReq !== 1'b1 || stall !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL inv_hold_req: cycle %0d got req=%b stall=%b, required 1/1", c, dmemReq, stall);
      end
      @(posedge clock); #1;
    end
    invalidate = 1'b0;
    dmemAck    = 1'b0;
    @(negedge clock);
    nCompared++;
    if (dmemReq !== 1'b0 || stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL inv_release: got req=%b stall=%b, required 0/0", dmemReq, stall);
    end
    @(posedge clock); #1;

    // Invalidate coincident with ack.
    applyStimulus(MEM_LOAD, SIZE_WORD, 1'b0, 32'h6004, 32'h0, 5'd8, 1'b1);
    @(posedge clock); #1;
    exIf.valid = 1'b0;
    invalidate = 1'b1;
    dmemAck    = 1'b1;
    @(posedge clock); #1;
    invalidate = 1'b0;
    dmemAck    = 1'b0;
    @(negedge clock);
    nCompared++;
    if (dmemReq !== 1'b0 || stall !== 1'b0 || wbIf.valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL inv_with_ack: got req=%b stall=%b valid=%b, required 0/0/0", dmemReq, stall, wbIf.valid);
    end
    @(posedge clock); #1;

    // Invalidate in IDLE discards the offered instruction, memory or not.
    applyStimulus(MEM_NONE, SIZE_WORD, 1'b0, 32'h99, 32'h0, 5'd2, 1'b1);
    invalidate = 1'b1;
    @(posedge clock); #1;
    applyStimulus(MEM_LOAD, SIZE_WORD, 1'b0, 32'h7000, 32'h0, 5'd2, 1'b1);
    @(posedge clock); #1;
    exIf.valid = 1'b0;
    invalidate = 1'b0;
    @(negedge clock);
    nCompared++;
    if (dmemReq !== 1'b0 || wbIf.valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL inv_idle: got req=%b valid=%b, required 0/0", dmemReq, wbIf.valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_req();
    applyStimulus(MEM_STORE, SIZE_WORD, 1'b0, 32'h8000, 32'h0BAD_F00D, 5'd1, 1'b0);
    @(posedge clock); #1;
    exIf.valid = 1'b0;
    @(negedge clock);
    nCompared++;
    if (dmemReq !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rst_pre_req: got %b, required 1", dmemReq);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    nCompared++;
    if (dmemReq !== 1'b0 || stall !== 1'b0 || wbIf.valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid_req: got req=%b stall=%b valid=%b, required 0/0/0", dmemReq, stall, wbIf.valid);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    exIf        = '0;
    invalidate  = 1'b0;
    dmemAck     = 1'b0;
    dmemRdata   = 32'h0;
    reset       = 1'b1;
    test_reset();
    test_nonmem_stream();
    test_load();
    test_store();
    test_misaligned();
    test_invalidate();
    test_reset_mid_req();
    repeat (2) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL missing_wb: got %0d pending, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
